// File: rtl/dht_pkg.sv
// Shared definitions for the multi-channel DHT11 request controller:
// request/status codes, frame byte positions, FSM encoding and frame helpers.
package dht_pkg;

  localparam int FRAME_W = 40;

  // Byte k of a frame sits at frame[8k+7:8k], first-received bit at frame[8k].
  localparam logic [2:0] BYTE_HUM_INT   = 3'd0;
  localparam logic [2:0] BYTE_HUM_FRAC  = 3'd1;
  localparam logic [2:0] BYTE_TEMP_INT  = 3'd2;
  localparam logic [2:0] BYTE_TEMP_FRAC = 3'd3;
  localparam logic [2:0] BYTE_CHECKSUM  = 3'd4;

  localparam logic [7:0] INFO_INVALID = 8'hFF;

  typedef enum logic [1:0] {
    REQ_HUM_INT   = 2'b00,
    REQ_TEMP_INT  = 2'b01,
    REQ_STATUS    = 2'b10,
    REQ_TEMP_FRAC = 2'b11
  } req_code_t;

  // Cause of the last attempt; its value is also the status response byte.
  typedef enum logic [1:0] {
    CAUSE_OK       = 2'd0,
    CAUSE_TIMEOUT  = 2'd1,
    CAUSE_DRV_ERR  = 2'd2,
    CAUSE_CHECKSUM = 2'd3
  } cause_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST_PULSE,
    ST_SETTLE,
    ST_START,
    ST_WAIT,
    ST_CHECK,
    ST_RESPOND
  } state_t;

  // Returns byte k in normal bit order (bits arrive MSB first, stored LSB first).
  function automatic logic [7:0] frame_byte(input logic [FRAME_W-1:0] f, input logic [2:0] k);
    logic [7:0] raw;
    case (k)
      BYTE_HUM_INT:   raw = f[7:0];
      BYTE_HUM_FRAC:  raw = f[15:8];
      BYTE_TEMP_INT:  raw = f[23:16];
      BYTE_TEMP_FRAC: raw = f[31:24];
      default:        raw = f[39:32];
    endcase
    frame_byte = {<<{raw}};
  endfunction

  function automatic logic checksum_ok(input logic [FRAME_W-1:0] f);
    logic [7:0] sum;
    sum = frame_byte(f, BYTE_HUM_INT) + frame_byte(f, BYTE_HUM_FRAC) +
          frame_byte(f, BYTE_TEMP_INT) + frame_byte(f, BYTE_TEMP_FRAC);
    checksum_ok = (sum == frame_byte(f, BYTE_CHECKSUM));
  endfunction

  // Response byte for a request answered with good data.
  function automatic logic [7:0] answer(input req_code_t code, input logic [FRAME_W-1:0] f,
                                        input cause_t cause);
    case (code)
      REQ_HUM_INT:   answer = frame_byte(f, BYTE_HUM_INT);
      REQ_TEMP_INT:  answer = frame_byte(f, BYTE_TEMP_INT);
      REQ_TEMP_FRAC: answer = frame_byte(f, BYTE_TEMP_FRAC);
      default:       answer = {6'b0, cause};
    endcase
  endfunction

endpackage

// File: rtl/dht_multi_request_ctrl_if.sv
// Request/response handshake between the main control FSM (master) and the
// DHT request controller (slave).
//   req_valid/req_ready/req_channel/req_code : request channel
//   resp_valid/resp_ready/information/resp_error : response channel
interface dht_multi_request_ctrl_if #(
  parameter int CH_W = 2
);
  logic            req_valid;
  logic            req_ready;
  logic [CH_W-1:0] req_channel;
  logic [1:0]      req_code;
  logic            resp_valid;
  logic            resp_ready;
  logic [7:0]      information;
  logic            resp_error;

  modport master (
    output req_valid, req_channel, req_code, resp_ready,
    input  req_ready, resp_valid, information, resp_error
  );

  modport slave (
    input  req_valid, req_channel, req_code, resp_ready,
    output req_ready, resp_valid, information, resp_error
  );
endinterface

// File: rtl/dht_cycle_timer.sv
// Loadable down-counter. load/value start a new interval; done is high while
// the count is zero, so loading N-1 gives an interval of exactly N cycles.
//   clock, rst_n : clock and async active-low reset
//   load, value  : start interval
//   done         : interval finished
module dht_cycle_timer #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         done
);
  logic [W-1:0] count;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == '0);
endmodule

// File: rtl/dht_multi_request_ctrl.sv
// Serves byte-wide DHT11 info requests for CHANNELS sensors. A miss runs a
// reset pulse / settle / start / wait sequence on the selected driver, checks
// the frame and retries up to MAX_RETRY times; good frames are cached for
// CACHE_CYCLES cycles and later requests inside that window are answered
// directly.
//   clock, rst_n      : clock and async active-low reset
//   bus (slave)       : request/response handshake
//   drv_rst/drv_start : per-channel driver reset and one-cycle start pulse
//   drv_frame/drv_done/drv_error : per-channel driver results
module dht_multi_request_ctrl
  import dht_pkg::*;
#(
  parameter int CHANNELS       = 4,
  parameter int CH_W           = 2,
  parameter int RST_CYCLES     = 100_000_000,
  parameter int SETTLE_CYCLES  = 1_000,
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int MAX_RETRY      = 2,
  parameter int CACHE_CYCLES   = 100_000_000
) (
  input  logic                      clock,
  input  logic                      rst_n,
  dht_multi_request_ctrl_if.slave   bus,
  output logic [CHANNELS-1:0]       drv_rst,
  output logic [CHANNELS-1:0]       drv_start,
  input  logic [FRAME_W*CHANNELS-1:0] drv_frame,
  input  logic [CHANNELS-1:0]       drv_done,
  input  logic [CHANNELS-1:0]       drv_error
);
  localparam int CNT_W = 32;
  localparam int NSLOT = 1 << CH_W;  // every req_channel value has a slot
  localparam logic [CNT_W-1:0] RST_LOAD     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] AGE_MAX      = CNT_W'(CACHE_CYCLES);
  localparam logic [7:0]       RETRY_LIM    = 8'(MAX_RETRY);

  state_t state, next_state;
  logic [CH_W-1:0] ch_q;
  req_code_t       code_q;
  logic [7:0]      retry_q;
  logic [7:0]      info_q;
  logic            err_q;

  logic            tmr_load, tmr_done;
  logic [CNT_W-1:0] tmr_value;
  logic            retry_inc, store_en, fail, resp_load, resp_err_n;
  cause_t          fail_cause;
  logic [7:0]      resp_info_n;
  logic            req_ch_ok;

  logic [FRAME_W-1:0] frame_in    [NSLOT];
  logic               done_in     [NSLOT];
  logic               error_in    [NSLOT];
  logic [FRAME_W-1:0] cache_frame [NSLOT];
  logic               cache_valid [NSLOT];
  logic [CNT_W-1:0]   cache_age   [NSLOT];
  cause_t             cache_cause [NSLOT];

  dht_cycle_timer #(.W(CNT_W)) u_timer (
    .clock (clock),
    .rst_n (rst_n),
    .load  (tmr_load),
    .value (tmr_value),
    .done  (tmr_done)
  );

  assign req_ch_ok       = 32'(bus.req_channel) < 32'(CHANNELS);
  assign bus.req_ready   = rst_n && (state == ST_IDLE);
  assign bus.resp_valid  = (state == ST_RESPOND);
  assign bus.information = info_q;
  assign bus.resp_error  = err_q;

  for (genvar c = 0; c < NSLOT; c++) begin : g_slot
    logic               sel;
    logic               valid_r;
    logic [CNT_W-1:0]   age_r;
    cause_t             cause_r;
    logic [FRAME_W-1:0] frame_r;

    assign sel = (ch_q == CH_W'(c));

    if (c < CHANNELS) begin : g_io
      assign frame_in[c]  = drv_frame[FRAME_W*c +: FRAME_W];
      assign done_in[c]   = drv_done[c];
      assign error_in[c]  = drv_error[c];
      assign drv_rst[c]   = sel && (state == ST_RST_PULSE);
      assign drv_start[c] = sel && (state == ST_START);
    end else begin : g_tie
      assign frame_in[c] = '0;
      assign done_in[c]  = 1'b0;
      assign error_in[c] = 1'b0;
    end

    // A failed read leaves an existing entry untouched; only the cause moves.
    always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
        valid_r <= 1'b0;
        age_r   <= '0;
        cause_r <= CAUSE_OK;
      end else begin
        if (store_en && sel) begin
          valid_r <= 1'b1;
          age_r   <= '0;
        end else if (valid_r && age_r < AGE_MAX) begin
          age_r <= age_r + CNT_W'(1);
        end
        if (fail && sel) cause_r <= fail_cause;
        else if (store_en && sel) cause_r <= CAUSE_OK;
      end
    end

    // NOTE: frame storage has no reset; valid_r alone decides whether it is read.
    always_ff @(posedge clock) begin
      if (store_en && sel) frame_r <= frame_in[c];
    end

    assign cache_valid[c] = valid_r;
    assign cache_age[c]   = age_r;
    assign cache_cause[c] = cause_r;
    assign cache_frame[c] = frame_r;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      ch_q    <= '0;
      code_q  <= REQ_HUM_INT;
      retry_q <= '0;
      info_q  <= 8'h00;
      err_q   <= 1'b0;
    end else begin
      state <= next_state;
      if (state == ST_IDLE && bus.req_valid) begin
        ch_q   <= bus.req_channel;
        code_q <= req_code_t'(bus.req_code);
      end
      if (retry_inc) retry_q <= retry_q + 8'd1;
      else if (state == ST_RESPOND && bus.resp_ready) retry_q <= '0;
      if (resp_load) begin
        info_q <= resp_info_n;
        err_q  <= resp_err_n;
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    next_state  = state;
    tmr_load    = 1'b0;
    tmr_value   = '0;
    retry_inc   = 1'b0;
    store_en    = 1'b0;
    fail        = 1'b0;
    fail_cause  = CAUSE_OK;
    resp_load   = 1'b0;
    resp_info_n = 8'h00;
    resp_err_n  = 1'b0;
    case (state)
      ST_IDLE: if (bus.req_valid) begin
        if (!req_ch_ok) begin
          next_state  = ST_RESPOND;
          resp_load   = 1'b1;
          resp_info_n = INFO_INVALID;
          resp_err_n  = 1'b1;
        end else if (cache_valid[bus.req_channel] && cache_age[bus.req_channel] < AGE_MAX) begin
          next_state  = ST_RESPOND;
          resp_load   = 1'b1;
          resp_info_n = answer(req_code_t'(bus.req_code), cache_frame[bus.req_channel],
                               cache_cause[bus.req_channel]);
        end else begin
          next_state = ST_RST_PULSE;
          tmr_load   = 1'b1;
          tmr_value  = RST_LOAD;
        end
      end
      ST_RST_PULSE: if (tmr_done) begin
        next_state = ST_SETTLE;
        tmr_load   = 1'b1;
        tmr_value  = SETTLE_LOAD;
      end
      ST_SETTLE: if (tmr_done) next_state = ST_START;
      ST_START: begin
        next_state = ST_WAIT;
        tmr_load   = 1'b1;
        tmr_value  = TIMEOUT_LOAD;
      end
      // drv_done is tested first so it wins over a coinciding timeout.
      ST_WAIT: begin
        if (done_in[ch_q]) begin
          next_state = ST_CHECK;
        end else if (tmr_done) begin
          fail       = 1'b1;
          fail_cause = CAUSE_TIMEOUT;
        end
      end
      ST_CHECK: begin
        if (error_in[ch_q]) begin
          fail       = 1'b1;
          fail_cause = CAUSE_DRV_ERR;
        end else if (!checksum_ok(frame_in[ch_q])) begin
          fail       = 1'b1;
          fail_cause = CAUSE_CHECKSUM;
        end else begin
          store_en    = 1'b1;
          next_state  = ST_RESPOND;
          resp_load   = 1'b1;
          resp_info_n = answer(code_q, frame_in[ch_q], CAUSE_OK);
        end
      end
      ST_RESPOND: if (bus.resp_ready) next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase

    if (fail) begin
      if (retry_q < RETRY_LIM) begin
        retry_inc  = 1'b1;
        next_state = ST_RST_PULSE;
        tmr_load   = 1'b1;
        tmr_value  = RST_LOAD;
      end else begin
        next_state = ST_RESPOND;
        resp_load  = 1'b1;
        if (code_q == REQ_STATUS) begin
          resp_info_n = {6'b0, fail_cause};
        end else begin
          resp_info_n = INFO_INVALID;
          resp_err_n  = 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_dht_multi_request_ctrl.sv
// Directed bench for dht_multi_request_ctrl with two channels and short timing.
// The bench plays the main FSM on the interface and the DHT11 drivers on the
// drv_* ports; every expected value is hand-derived from the sensor bytes.
module tb_dht_multi_request_ctrl;
  localparam int CHANNELS = 2;
  localparam int CH_W     = 2;
  localparam int RST      = 20;
  localparam int SETTLE   = 5;
  localparam int TIMEOUT  = 100;
  localparam int CACHE    = 1000;

  localparam int M_DONE    = 0;
  localparam int M_TIMEOUT = 1;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  drv_rst, drv_start, drv_done, drv_error;
  logic [79:0] drv_frame;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  dht_multi_request_ctrl_if #(.CH_W(CH_W)) bus ();

  dht_multi_request_ctrl #(
    .CHANNELS       (CHANNELS),
    .CH_W           (CH_W),
    .RST_CYCLES     (RST),
    .SETTLE_CYCLES  (SETTLE),
    .TIMEOUT_CYCLES (TIMEOUT),
    .MAX_RETRY      (2),
    .CACHE_CYCLES   (CACHE)
  ) dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .bus       (bus),
    .drv_rst   (drv_rst),
    .drv_start (drv_start),
    .drv_frame (drv_frame),
    .drv_done  (drv_done),
    .drv_error (drv_error)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bytes as transmitted: byte k at [8k+7:8k], its MSB at bit 8k.
  function automatic logic [39:0] make_frame(input logic [7:0] b0, b1, b2, b3, b4);
    logic [7:0]  b [5];
    logic [39:0] f;
    b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3; b[4] = b4;
    for (int k = 0; k < 5; k++)
      for (int i = 0; i < 8; i++) f[8*k+i] = b[k][7-i];
    return f;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_req(input logic [1:0] ch, input logic [1:0] code);
    int n;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 50) begin tick(); n++; end
    check("req_ready_before_req", bus.req_ready, 1);
    bus.req_valid   = 1'b1;
    bus.req_channel = ch;
    bus.req_code    = code;
    tick();
    bus.req_valid   = 1'b0;
  endtask

  // Walks through the reset pulse and settle phase up to the start pulse.
  task automatic await_start(input logic ch, output int rst_cnt, output int settle_cnt);
    int   n;
    logic other;
    rst_cnt = 0; settle_cnt = 0; other = 1'b0; n = 0;
    while (drv_start[ch] !== 1'b1 && n < 200) begin
      if (drv_rst[ch]) rst_cnt++;
      else settle_cnt++;
      other = other | drv_rst[!ch] | drv_start[!ch];
      tick(); n++;
    end
    check("start_seen", drv_start[ch], 1);
    check("other_channel_quiet", other, 0);
  endtask

  // Called at the start-pulse sample; ends one cycle after the attempt resolves.
  task automatic respond(input logic ch, input int mode, input logic [39:0] f, input logic err);
    int n;
    tick();
    check("start_one_cycle", drv_start[ch], 0);
    if (mode == M_TIMEOUT) begin
      n = 0;
      while (drv_rst[ch] !== 1'b1 && n < 300) begin tick(); n++; end
      check("timeout_cycles", n, TIMEOUT);
    end else begin
      tick(); tick();
      if (ch) drv_frame[79:40] = f;
      else    drv_frame[39:0]  = f;
      drv_error[ch] = err;
      drv_done[ch]  = 1'b1;
      tick();
      drv_done[ch]  = 1'b0;
      tick();
    end
  endtask

  task automatic attempt(input logic ch, input int mode, input logic [39:0] f, input logic err);
    int rc, sc;
    await_start(ch, rc, sc);
    check("rst_pulse_cycles", rc, RST);
    check("settle_cycles", sc, SETTLE);
    respond(ch, mode, f, err);
  endtask

  task automatic finish_resp(input string tag, input logic [7:0] exp_info, input logic exp_err);
    int n;
    n = 0;
    while (bus.resp_valid !== 1'b1 && n < 20) begin tick(); n++; end
    check({tag, "_resp_valid"}, bus.resp_valid, 1);
    check({tag, "_information"}, bus.information, exp_info);
    check({tag, "_resp_error"}, bus.resp_error, exp_err);
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    check({tag, "_resp_valid_drop"}, bus.resp_valid, 0);
    check({tag, "_req_ready_back"}, bus.req_ready, 1);
  endtask

  initial begin
    logic [39:0] frame_a, frame_bad, frame_c;
    frame_a   = make_frame(8'd45, 8'd0, 8'd27, 8'd0, 8'd72);
    frame_bad = make_frame(8'd45, 8'd0, 8'd27, 8'd0, 8'd73);
    frame_c   = make_frame(8'd60, 8'd5, 8'd22, 8'd9, 8'd96);

    bus.req_valid = 1'b0; bus.req_channel = '0; bus.req_code = '0; bus.resp_ready = 1'b0;
    drv_frame = '0; drv_done = '0; drv_error = '0;

    // Reset values
    repeat (3) tick();
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_information", bus.information, 8'h00);
    check("rst_resp_error", bus.resp_error, 0);
    check("rst_drv_rst", drv_rst, 2'b00);
    check("rst_drv_start", drv_start, 2'b00);
    rst_n = 1'b1;
    tick();
    check("post_rst_req_ready", bus.req_ready, 1);

    // Full read of ch1 temperature
    send_req(2'd1, 2'b01);
    attempt(1'b1, M_DONE, frame_a, 1'b0);
    finish_resp("t1_temp", 8'd27, 1'b0);

    // Cache hits on ch1: answered at N+1 with no driver activity
    send_req(2'd1, 2'b00);
    check("t2_hit_valid_n1", bus.resp_valid, 1);
    check("t2_hit_no_drv", {drv_rst, drv_start}, 4'b0000);
    finish_resp("t2_hum", 8'd45, 1'b0);
    send_req(2'd1, 2'b10);
    check("t2s_hit_valid_n1", bus.resp_valid, 1);
    finish_resp("t2_status", 8'h00, 1'b0);

    // Bad checksum on all three attempts on ch0
    send_req(2'd0, 2'b01);
    for (int a = 0; a < 3; a++) attempt(1'b0, M_DONE, frame_bad, 1'b0);
    finish_resp("t3_cksum", 8'hFF, 1'b1);
    send_req(2'd0, 2'b10);
    for (int a = 0; a < 3; a++) attempt(1'b0, M_DONE, frame_bad, 1'b0);
    finish_resp("t3_status", 8'h03, 1'b0);

    // Reset while waiting for the driver
    send_req(2'd0, 2'b00);
    begin
      int rc, sc;
      await_start(1'b0, rc, sc);
    end
    tick(); tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_req_ready", bus.req_ready, 0);
    check("mid_rst_resp_valid", bus.resp_valid, 0);
    check("mid_rst_outputs", {bus.information, bus.resp_error}, 9'h000);
    check("mid_rst_drv", {drv_rst, drv_start}, 4'b0000);
    tick();
    rst_n = 1'b1;
    tick();
    check("after_rst_req_ready", bus.req_ready, 1);
    send_req(2'd1, 2'b01);
    attempt(1'b1, M_DONE, frame_a, 1'b0);
    finish_resp("t6_reread", 8'd27, 1'b0);

    // Timeout, then driver error, then success on ch0
    send_req(2'd0, 2'b11);
    attempt(1'b0, M_TIMEOUT, frame_c, 1'b0);
    attempt(1'b0, M_DONE, frame_c, 1'b1);
    attempt(1'b0, M_DONE, frame_c, 1'b0);
    finish_resp("t4_frac", 8'd9, 1'b0);
    send_req(2'd0, 2'b10);
    finish_resp("t4_status", 8'h00, 1'b0);
    send_req(2'd0, 2'b00);
    finish_resp("t4_hum", 8'd60, 1'b0);

    // Invalid channel, response held while resp_ready stays low
    send_req(2'd3, 2'b00);
    check("t5_valid_n1", bus.resp_valid, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t5_hold_valid", bus.resp_valid, 1);
      check("t5_hold_info", bus.information, 8'hFF);
      check("t5_hold_err", bus.resp_error, 1);
      check("t5_no_drv", {drv_rst, drv_start}, 4'b0000);
    end
    finish_resp("t5_invalid", 8'hFF, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dht_multi_request_ctrl.md
Name: dht_multi_request_ctrl

Overview:
Parametrised successor to the single-sensor DHT11 request FSM. Serves byte-wide info requests (humidity, temperature, fractions, status) for CHANNELS DHT11 sensors through a valid/ready request/response handshake. Drives per-channel DHT11 driver instances with a reset pulse and a start pulse. Adds checksum verification, a response timeout, bounded retries and a per-channel result cache that enforces the sensor's minimum read interval. It sits between the main control FSM and the per-channel DHT11 driver instances.

Parameters:
CHANNELS, 4, number of sensors/drivers (1..16)
CH_W, 2, width of req_channel (>= clog2(CHANNELS), min 1)
RST_CYCLES, 100_000_000, cycles drv_rst is held high before the settle phase
SETTLE_CYCLES, 1_000, cycles between drv_rst release and drv_start
TIMEOUT_CYCLES, 50_000_000, max cycles from drv_start to drv_done
MAX_RETRY, 2, extra read attempts after a failed attempt
CACHE_CYCLES, 100_000_000, lifetime of a good frame; hits in this window are answered from cache

Ports:
clock  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  high only in IDLE
req_channel  in  CH_W  target sensor
req_code  in  2  00 hum_int, 01 temp_int, 10 status, 11 temp_frac
resp_valid  out  1  response present; held until resp_ready
resp_ready  in  1  consumer accepts response
information  out  8  response byte
resp_error  out  1  request failed (invalid channel or retries exhausted)
drv_rst  out  CHANNELS  per-channel driver reset
drv_start  out  CHANNELS  per-channel one-cycle start pulse
drv_frame  in  40*CHANNELS  channel c frame at [40c+39:40c]
drv_done  in  CHANNELS  frame complete
drv_error  in  CHANNELS  driver-reported error

Behaviour:
- Reset (async, rst_n=0): state IDLE. req_ready=0 while rst_n low, 1 in the first cycle after. resp_valid=0, information=8'h00, resp_error=0, drv_rst=0, drv_start=0. All cache-valid bits, age counters, retry and timer counters cleared. Reset mid-operation aborts with no response.
- Frame byte k (k=0 hum_int, 1 hum_frac, 2 temp_int, 3 temp_frac, 4 checksum) lives at frame[8k+7:8k], with frame[8k] the byte MSB (first bit received). So information[7-i] = frame[8k+i].
- Checksum is good iff (b0+b1+b2+b3) mod 256 == b4.
- States: IDLE, RST_PULSE, SETTLE, START, WAIT, CHECK, RESPOND.
- IDLE: on req_valid, latch channel/code (accept cycle N), then:
  - channel >= CHANNELS -> RESPOND with information=8'hFF, resp_error=1.
  - cache valid and age < CACHE_CYCLES -> RESPOND from cache; resp_valid rises at N+1.
  - otherwise -> RST_PULSE.
- RST_PULSE: drv_rst[ch]=1 for exactly RST_CYCLES cycles -> SETTLE.
- SETTLE: SETTLE_CYCLES cycles -> START.
- START: drv_start[ch]=1 for exactly one cycle -> WAIT; timeout counter cleared.
- WAIT: on drv_done[ch] -> CHECK. If TIMEOUT_CYCLES elapse first, the attempt fails with cause timeout. If drv_done and timeout coincide, drv_done wins.
- CHECK (1 cycle): attempt fails with cause driver_err if drv_error[ch]=1, else cause checksum if the checksum is bad. Otherwise store the frame in the cache, set valid, clear age -> RESPOND.
- Failed attempt: if retry count < MAX_RETRY, increment it -> RST_PULSE. Else -> RESPOND with resp_error=1.
- RESPOND, successful or cached data requests: information = selected byte; resp_error=0.
- RESPOND, failed data requests: information=8'hFF, resp_error=1.
- Status request (code 10): information = 00 ok, 01 timeout, 02 driver_err, 03 checksum (last cause); resp_error=0 unless the channel is invalid.
- RESPOND: hold resp_valid, information and resp_error stable until resp_ready=1. Then -> IDLE, resp_valid=0, retry count cleared.
- Age counters: one per channel; increment every cycle while valid and saturate at CACHE_CYCLES. A failed read does not invalidate an existing cache entry.
- Only the selected channel's drv_rst/drv_start bits ever assert. Drivers are held with drv_rst=0 otherwise.

Decomposition:
- Shared package dht_pkg: request code constants, status code constants, byte index constants (BYTE_HUM_INT..BYTE_CHECKSUM), FRAME_W=40, state encoding.
- One sub-module: dht_cycle_timer. A loadable down-counter with a done flag, reused for RST_PULSE, SETTLE and WAIT.
- Cache and age counters stay inline.

Test Plan:
- CHANNELS=2, RST_CYCLES=20, SETTLE_CYCLES=5, TIMEOUT_CYCLES=100. Request ch1 code 01; driver returns bytes 45,0,27,0,72 -> drv_rst[1] high 20 cycles, one drv_start pulse, information=27, resp_error=0.
- Same frame, then request ch1 code 00 within CACHE_CYCLES -> no drv_rst/drv_start activity, resp_valid at N+1, information=45.
- Checksum byte 73 on every attempt, MAX_RETRY=2 -> 3 reset/start sequences, resp_error=1, information=8'hFF. A following status request -> information=03.
- Driver never asserts drv_done -> timeout after 100 cycles per attempt. Then drv_error on the retry, success on the third attempt -> data returned with resp_error=0.
- req_channel=3 with CHANNELS=2 -> immediate response 8'hFF, resp_error=1, no driver activity. Hold resp_ready=0 for 10 cycles -> outputs stable throughout.
- Drop rst_n low during WAIT -> all outputs at reset values at once. After release: req_ready=1 and the cache is empty (the next request performs a full read).
